// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out TX serializer.
package serializer_pkg;

    // Default word width of the serializer.
    localparam int DEF_DATA_W = 8;

    // Shift engine states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } ser_state_t;

    // Fold one driven bit into the running parity accumulator.
    function automatic logic par_step(input logic acc, input logic data_bit);
        return acc ^ data_bit;
    endfunction

    // Final parity bit: XOR of all data bits, inverted for odd parity.
    function automatic logic par_final(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer between the word producer and the shift engine.
// Ready is the registered inverse of the full flag, so valid never reaches
// ready combinationally.
module ser_hold_buf
    import serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_drain,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    assign w_accept = i_valid & ~r_full;

    // Capture the word on accept; the engine clears the entry when it loads it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_data <= i_data;
            end
            r_full <= w_accept | (r_full & ~i_drain);
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out engine for the TX datapath.
// Words enter a one-entry holding buffer and are shifted out one bit per
// ser_en strobe, optionally followed by a parity bit; words chain with no
// idle bit between them.
//
// Handshake: a word transfers on a rising clk edge where data_valid and
// data_ready are both high. data_ready depends only on registered state.
module piso_serializer
    import serializer_pkg::*;
#(
    parameter int   DATA_W    = DEF_DATA_W,
    parameter bit   LSB_FIRST = 1'b1,
    parameter bit   PAR_EN    = 1'b0,
    parameter bit   PAR_ODD   = 1'b0,
    parameter logic IDLE_LVL  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              ser_en,
    output logic              ser_data,
    output logic              busy,
    output logic              ser_done
);

    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    ser_state_t        r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_par, w_par_nxt;
    logic              r_ser, w_ser_nxt;
    logic              r_done, w_done_nxt;

    logic              w_drain;
    logic              w_buf_full;
    logic [DATA_W-1:0] w_buf_data;
    logic              w_word_end;

    logic              w_cur_bit;
    logic [DATA_W-1:0] w_cur_shift;
    logic              w_new_bit;
    logic [DATA_W-1:0] w_new_shift;

    ser_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .i_data  (p_data),
        .i_valid (data_valid),
        .o_ready (data_ready),
        .i_drain (w_drain),
        .o_full  (w_buf_full),
        .o_data  (w_buf_data)
    );

    // Next bit to drive and the remaining shift contents, for the current
    // word and for a word taken straight from the buffer at a word end.
    assign w_cur_bit   = LSB_FIRST ? r_shreg[0] : r_shreg[DATA_W-1];
    assign w_cur_shift = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);
    assign w_new_bit   = LSB_FIRST ? w_buf_data[0] : w_buf_data[DATA_W-1];
    assign w_new_shift = LSB_FIRST ? (w_buf_data >> 1) : (w_buf_data << 1);

    // Next-state and datapath decisions; every register holds unless a case updates it.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_ser_nxt   = r_ser;
        w_done_nxt  = 1'b0;
        w_drain     = 1'b0;
        w_word_end  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Loading needs no strobe; the line stays idle until the first ser_en.
                w_ser_nxt = IDLE_LVL;
                if (w_buf_full) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = w_buf_data;
                    w_cnt_nxt   = '0;
                    w_par_nxt   = 1'b0;
                    w_drain     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ser_en) begin
                    if (r_cnt != LAST_CNT) begin
                        w_ser_nxt   = w_cur_bit;
                        w_shreg_nxt = w_cur_shift;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_par_nxt   = par_step(r_par, w_cur_bit);
                    end else if (PAR_EN) begin
                        w_ser_nxt   = par_final(r_par, PAR_ODD);
                        w_state_nxt = ST_PARITY;
                    end else begin
                        w_word_end = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (ser_en) begin
                    w_word_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A waiting word starts on the word-end strobe itself, so no idle bit appears.
        if (w_word_end) begin
            w_done_nxt = 1'b1;
            if (w_buf_full) begin
                w_state_nxt = ST_SHIFT;
                w_drain     = 1'b1;
                w_ser_nxt   = w_new_bit;
                w_shreg_nxt = w_new_shift;
                w_cnt_nxt   = CNT_W'(1);
                w_par_nxt   = par_step(1'b0, w_new_bit);
            end else begin
                w_state_nxt = ST_IDLE;
                w_ser_nxt   = IDLE_LVL;
            end
        end
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_ser   <= IDLE_LVL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_par   <= w_par_nxt;
            r_ser   <= w_ser_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ser_data = r_ser;
    assign ser_done = r_done;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: three instances cover LSB-first
// without parity, MSB-first with even parity, and a 4-bit word with odd parity.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Instance A: DATA_W=8, LSB first, no parity
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_en, a_ser, a_busy, a_done;
    // Instance B: DATA_W=8, MSB first, even parity
    logic [7:0] b_data;
    logic       b_valid, b_ready, b_en, b_ser, b_busy, b_done;
    // Instance C: DATA_W=4, LSB first, odd parity
    logic [3:0] c_data;
    logic       c_valid, c_ready, c_en, c_ser, c_busy, c_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];
    logic       bit_q[$];

    always #5 clk = ~clk;

    piso_serializer #(
        .DATA_W(8), .LSB_FIRST(1'b1), .PAR_EN(1'b0), .PAR_ODD(1'b0), .IDLE_LVL(1'b1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .p_data(a_data), .data_valid(a_valid), .data_ready(a_ready),
        .ser_en(a_en), .ser_data(a_ser), .busy(a_busy), .ser_done(a_done)
    );

    piso_serializer #(
        .DATA_W(8), .LSB_FIRST(1'b0), .PAR_EN(1'b1), .PAR_ODD(1'b0), .IDLE_LVL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .p_data(b_data), .data_valid(b_valid), .data_ready(b_ready),
        .ser_en(b_en), .ser_data(b_ser), .busy(b_busy), .ser_done(b_done)
    );

    piso_serializer #(
        .DATA_W(4), .LSB_FIRST(1'b1), .PAR_EN(1'b1), .PAR_ODD(1'b1), .IDLE_LVL(1'b1)
    ) u_dut_c (
        .clk(clk), .rst(rst), .p_data(c_data), .data_valid(c_valid), .data_ready(c_ready),
        .ser_en(c_en), .ser_data(c_ser), .busy(c_busy), .ser_done(c_done)
    );

    // One-cycle strobe on the selected instance; called and returns at a negedge.
    task automatic strobe(input int inst);
        case (inst)
            0:       a_en = 1'b1;
            1:       b_en = 1'b1;
            default: c_en = 1'b1;
        endcase
        @(negedge clk);
        a_en = 1'b0;
        b_en = 1'b0;
        c_en = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (a_ser   !== 1'b1) $display("FAIL rst_a_ser: got %b want 1", a_ser);     else n_pass++;
        n_checks++; if (a_busy  !== 1'b0) $display("FAIL rst_a_busy: got %b want 0", a_busy);   else n_pass++;
        n_checks++; if (a_done  !== 1'b0) $display("FAIL rst_a_done: got %b want 0", a_done);   else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL rst_a_ready: got %b want 1", a_ready); else n_pass++;
        n_checks++; if (b_ser   !== 1'b1) $display("FAIL rst_b_ser: got %b want 1", b_ser);     else n_pass++;
        n_checks++; if (b_busy  !== 1'b0) $display("FAIL rst_b_busy: got %b want 0", b_busy);   else n_pass++;
        n_checks++; if (b_done  !== 1'b0) $display("FAIL rst_b_done: got %b want 0", b_done);   else n_pass++;
        n_checks++; if (b_ready !== 1'b1) $display("FAIL rst_b_ready: got %b want 1", b_ready); else n_pass++;
        n_checks++; if (c_ser   !== 1'b1) $display("FAIL rst_c_ser: got %b want 1", c_ser);     else n_pass++;
        n_checks++; if (c_busy  !== 1'b0) $display("FAIL rst_c_busy: got %b want 0", c_busy);   else n_pass++;
        n_checks++; if (c_done  !== 1'b0) $display("FAIL rst_c_done: got %b want 0", c_done);   else n_pass++;
        n_checks++; if (c_ready !== 1'b1) $display("FAIL rst_c_ready: got %b want 1", c_ready); else n_pass++;
    endtask

    // 0xA5, LSB first, one strobe every 4th cycle.
    task automatic test_lsb_word();
        logic [7:0] w;
        logic       e_bit;
        logic       last_bit;
        w = 8'hA5;
        last_bit = 1'b1;
        a_data = w; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL t1_ready_after_accept: got %b want 0", a_ready); else n_pass++;
        for (int i = 0; i < 8; i++) bit_q.push_back(w[i]);
        @(negedge clk);
        n_checks++; if (a_busy !== 1'b1) $display("FAIL t1_busy_latency: got %b want 1", a_busy); else n_pass++;
        n_checks++; if (a_ser !== 1'b1) $display("FAIL t1_idle_before_strobe: got %b want 1", a_ser); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            repeat (3) @(negedge clk);
            n_checks++; if (a_ser !== last_bit) $display("FAIL t1_hold%0d: got %b want %b", i, a_ser, last_bit); else n_pass++;
            strobe(0);
            e_bit = bit_q.pop_front();
            last_bit = e_bit;
            n_checks++; if (a_ser !== e_bit) $display("FAIL t1_bit%0d: got %b want %b", i, a_ser, e_bit); else n_pass++;
            n_checks++; if (a_done !== 1'b0) $display("FAIL t1_early_done%0d: got %b want 0", i, a_done); else n_pass++;
        end
        repeat (3) @(negedge clk);
        strobe(0);
        n_checks++; if (a_done !== 1'b1) $display("FAIL t1_done: got %b want 1", a_done); else n_pass++;
        n_checks++; if (a_ser !== 1'b1) $display("FAIL t1_idle_after: got %b want 1", a_ser); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL t1_busy_after: got %b want 0", a_busy); else n_pass++;
        @(negedge clk);
        n_checks++; if (a_done !== 1'b0) $display("FAIL t1_done_pulse: got %b want 0", a_done); else n_pass++;
    endtask

    // 0x81, MSB first, even parity, random gaps between strobes.
    task automatic test_msb_parity();
        logic [7:0] w;
        logic       e_bit;
        w = 8'h81;
        b_data = w; b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        for (int i = 7; i >= 0; i--) bit_q.push_back(w[i]);
        bit_q.push_back(^w);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            strobe(1);
            e_bit = bit_q.pop_front();
            n_checks++; if (b_ser !== e_bit) $display("FAIL t2_bit%0d: got %b want %b", i, b_ser, e_bit); else n_pass++;
            n_checks++; if (b_done !== 1'b0) $display("FAIL t2_early_done%0d: got %b want 0", i, b_done); else n_pass++;
            n_checks++; if (b_busy !== 1'b1) $display("FAIL t2_busy%0d: got %b want 1", i, b_busy); else n_pass++;
        end
        strobe(1);
        n_checks++; if (b_done !== 1'b1) $display("FAIL t2_done: got %b want 1", b_done); else n_pass++;
        n_checks++; if (b_ser !== 1'b1) $display("FAIL t2_idle_after: got %b want 1", b_ser); else n_pass++;
        n_checks++; if (b_busy !== 1'b0) $display("FAIL t2_busy_after: got %b want 0", b_busy); else n_pass++;
    endtask

    // 0x0F offered while 0xF0 shifts: chained with no idle bit.
    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        logic       e_bit;
        int         done_cnt;
        w0 = 8'hF0; w1 = 8'h0F; done_cnt = 0;
        a_data = w0; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) bit_q.push_back(w0[i]);
        @(negedge clk);
        n_checks++; if (a_ready !== 1'b1) $display("FAIL t3_ready_after_load: got %b want 1", a_ready); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            strobe(0);
            e_bit = bit_q.pop_front();
            n_checks++; if (a_ser !== e_bit) $display("FAIL t3_pre_bit%0d: got %b want %b", i, a_ser, e_bit); else n_pass++;
        end
        a_data = w1; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL t3_ready_drop: got %b want 0", a_ready); else n_pass++;
        for (int i = 0; i < 8; i++) bit_q.push_back(w1[i]);
        for (int k = 0; k < 15; k++) begin
            strobe(0);
            if (a_done === 1'b1) done_cnt++;
            if (k < 14) begin
                e_bit = bit_q.pop_front();
                n_checks++; if (a_ser !== e_bit) $display("FAIL t3_bit%0d: got %b want %b", k, a_ser, e_bit); else n_pass++;
                n_checks++; if (a_busy !== 1'b1) $display("FAIL t3_busy%0d: got %b want 1", k, a_busy); else n_pass++;
                n_checks++; if (a_done !== (k == 6)) $display("FAIL t3_done%0d: got %b want %b", k, a_done, (k == 6)); else n_pass++;
            end else begin
                n_checks++; if (a_done !== 1'b1) $display("FAIL t3_final_done: got %b want 1", a_done); else n_pass++;
                n_checks++; if (a_ser !== 1'b1) $display("FAIL t3_final_idle: got %b want 1", a_ser); else n_pass++;
                n_checks++; if (a_busy !== 1'b0) $display("FAIL t3_final_busy: got %b want 0", a_busy); else n_pass++;
            end
        end
        n_checks++; if (done_cnt !== 2) $display("FAIL t3_done_count: got %0d want 2", done_cnt); else n_pass++;
    endtask

    // data_valid held high over 16 words; p_data junk whenever the buffer is full.
    task automatic test_hold_full();
        int         sent, got, mon_cnt, cyc;
        logic [7:0] asm_w, w;
        logic       en_prev, busy_prev;
        sent = 0; got = 0; mon_cnt = 0; cyc = 0;
        en_prev = 1'b0; busy_prev = 1'b0; asm_w = '0;
        while (got < 16 && cyc < 3000) begin
            if (en_prev && busy_prev) begin
                if (mon_cnt < 8) begin
                    asm_w[mon_cnt] = a_ser;
                    mon_cnt++;
                    n_checks++; if (a_done !== 1'b0) $display("FAIL t4_early_done: got %b want 0", a_done); else n_pass++;
                end else begin
                    n_checks++; if (a_done !== 1'b1) $display("FAIL t4_done: got %b want 1", a_done); else n_pass++;
                    if (exp_q.size() == 0) begin
                        n_checks++; $display("FAIL t4_extra_word: got %h want none", asm_w);
                    end else begin
                        w = exp_q.pop_front();
                        n_checks++; if (asm_w !== w) $display("FAIL t4_word%0d: got %h want %h", got, asm_w, w); else n_pass++;
                    end
                    got++;
                    if (a_busy === 1'b1) begin
                        asm_w[0] = a_ser;
                        mon_cnt = 1;
                    end else begin
                        mon_cnt = 0;
                        n_checks++; if (a_ser !== 1'b1) $display("FAIL t4_idle: got %b want 1", a_ser); else n_pass++;
                    end
                end
            end
            if (sent < 16) begin
                a_valid = 1'b1;
                a_data  = 8'($urandom);
                if (a_ready === 1'b1) begin
                    exp_q.push_back(a_data);
                    sent++;
                end
            end else begin
                a_valid = 1'b0;
            end
            a_en      = 1'($urandom_range(0, 1));
            en_prev   = a_en;
            busy_prev = a_busy;
            @(negedge clk);
            cyc++;
        end
        a_en = 1'b0; a_valid = 1'b0;
        n_checks++; if (got !== 16) $display("FAIL t4_word_count: got %0d want 16", got); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL t4_leftover: got %0d want 0", exp_q.size()); else n_pass++;
        exp_q.delete();
    endtask

    // Reset after 3 bits of 0x3C with another word waiting; nothing replays.
    task automatic test_reset_mid_word();
        logic [7:0] w, w2;
        logic       e_bit;
        w = 8'h3C; w2 = 8'h5A;
        a_data = w; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            strobe(0);
            n_checks++; if (a_ser !== w[i]) $display("FAIL t5_bit%0d: got %b want %b", i, a_ser, w[i]); else n_pass++;
        end
        a_data = 8'h99; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (a_ser !== 1'b1) $display("FAIL t5_rst_ser: got %b want 1", a_ser); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL t5_rst_busy: got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_done !== 1'b0) $display("FAIL t5_rst_done: got %b want 0", a_done); else n_pass++;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL t5_rst_ready: got %b want 1", a_ready); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) $display("FAIL t5_no_replay: got %b want 0", a_busy); else n_pass++;
        a_data = w2; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        for (int i = 0; i < 8; i++) bit_q.push_back(w2[i]);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            strobe(0);
            e_bit = bit_q.pop_front();
            n_checks++; if (a_ser !== e_bit) $display("FAIL t5_new_bit%0d: got %b want %b", i, a_ser, e_bit); else n_pass++;
        end
        strobe(0);
        n_checks++; if (a_done !== 1'b1) $display("FAIL t5_new_done: got %b want 1", a_done); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL t5_new_busy: got %b want 0", a_busy); else n_pass++;
    endtask

    // DATA_W=4 with odd parity, ser_en held high: one bit per clk, done every 5 cycles.
    task automatic test_stream_continuous();
        int         sent, got, mon_cnt, cyc, last_done;
        logic [3:0] asm_w;
        logic [7:0] w;
        logic       busy_prev, e_par;
        sent = 0; got = 0; mon_cnt = 0; cyc = 0; last_done = -1;
        busy_prev = 1'b0; asm_w = '0;
        c_en = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (busy_prev) begin
                if (mon_cnt < 4) begin
                    asm_w[mon_cnt] = c_ser;
                    mon_cnt++;
                    n_checks++; if (c_done !== 1'b0) $display("FAIL t6_early_done: got %b want 0", c_done); else n_pass++;
                end else if (mon_cnt == 4) begin
                    e_par = (exp_q.size() != 0) ? ~(^exp_q[0]) : 1'b0;
                    n_checks++; if (c_ser !== e_par) $display("FAIL t6_parity%0d: got %b want %b", got, c_ser, e_par); else n_pass++;
                    mon_cnt = 5;
                end else begin
                    n_checks++; if (c_done !== 1'b1) $display("FAIL t6_done: got %b want 1", c_done); else n_pass++;
                    if (exp_q.size() == 0) begin
                        n_checks++; $display("FAIL t6_extra_word: got %h want none", asm_w);
                    end else begin
                        w = exp_q.pop_front();
                        n_checks++; if ({4'b0, asm_w} !== w) $display("FAIL t6_word%0d: got %h want %h", got, asm_w, w); else n_pass++;
                    end
                    if (last_done >= 0) begin
                        n_checks++; if (cyc - last_done !== 5) $display("FAIL t6_period: got %0d want 5", cyc - last_done); else n_pass++;
                    end
                    last_done = cyc;
                    got++;
                    if (c_busy === 1'b1) begin
                        asm_w[0] = c_ser;
                        mon_cnt = 1;
                    end else begin
                        mon_cnt = 0;
                        n_checks++; if (c_ser !== 1'b1) $display("FAIL t6_idle: got %b want 1", c_ser); else n_pass++;
                    end
                end
            end
            if (sent < 4) begin
                c_valid = 1'b1;
                c_data  = 4'($urandom);
                if (c_ready === 1'b1) begin
                    exp_q.push_back({4'b0, c_data});
                    sent++;
                end
            end else begin
                c_valid = 1'b0;
            end
            busy_prev = c_busy;
            @(negedge clk);
            cyc++;
        end
        c_en = 1'b0; c_valid = 1'b0;
        n_checks++; if (got !== 4) $display("FAIL t6_word_count: got %0d want 4", got); else n_pass++;
        exp_q.delete();
    endtask

    initial begin
        a_data = '0; a_valid = 1'b0; a_en = 1'b0;
        b_data = '0; b_valid = 1'b0; b_en = 1'b0;
        c_data = '0; c_valid = 1'b0; c_en = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        test_lsb_word();
        test_msb_parity();
        test_back_to_back();
        test_hold_full();
        test_reset_mid_word();
        test_stream_continuous();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
